store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, the number of buffered store entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port st_valid, input, 1 bit: the CPU store request is valid this cycle.
REQ-005 The block SHALL have port st_addr, input, 32 bits: the byte address of the store.
REQ-006 The block SHALL have port st_data, input, 32 bits: the store data, right-justified (byte in [7:0], half in [15:0]).
REQ-007 The block SHALL have port st_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 The block SHALL have port st_ready, output, 1 bit: the buffer can accept a store this cycle.
REQ-009 The block SHALL have port mem_wr_req, output, 1 bit: a memory write is presented.
REQ-010 The block SHALL have port mem_addr, output, 32 bits: the word-aligned write address, with [1:0] always 00.
REQ-011 The block SHALL have port mem_wdata, output, 32 bits: the lane-positioned write data.
REQ-012 The block SHALL have port mem_byte_en, output, 4 bits: the byte-lane enables; bit n enables bits [8n+7:8n].
REQ-013 The block SHALL have port mem_wr_ack, input, 1 bit: memory accepted the presented write this cycle.
REQ-014 The block SHALL have port count, output, 5 bits: the number of occupied entries.
REQ-015 The block SHALL have port align_err, output, 1 bit: a one-cycle pulse flagging that a rejected store was dropped.

Function
REQ-016 A store SHALL be accepted in a cycle iff st_valid and st_ready are both 1 at the rising edge.
REQ-017 st_ready SHALL equal (count != DEPTH); a pop in the same cycle SHALL NOT make a full buffer ready (no bypass).
REQ-018 Each accepted legal store SHALL be formatted and enqueued as follows:
  - byte: mem_byte_en = 1 << st_addr[1:0]; st_data[7:0] replicated to all four lanes.
  - half: mem_byte_en = 0011 if st_addr[1]=0, else 1100; st_data[15:0] replicated to both halves.
  - word: mem_byte_en = 1111; data unchanged.
  - address: st_addr[31:2] with [1:0] forced to 00.
REQ-019 An accepted store SHALL be illegal if size is 11, size is half with st_addr[0]=1, or size is word with st_addr[1:0]!=00.
REQ-020 An illegal store SHALL be consumed, SHALL NOT be enqueued, and SHALL cause align_err=1 for exactly the next cycle.
REQ-021 mem_wr_req SHALL equal (count != 0); mem_addr, mem_wdata and mem_byte_en SHALL reflect the head entry.
REQ-022 The memory outputs SHALL be held stable while mem_wr_req=1 and mem_wr_ack=0.
REQ-023 The head entry SHALL be popped at the edge where mem_wr_req=1 and mem_wr_ack=1, and the next entry SHALL be presented the following cycle.
  - mem_wr_req SHALL stay 1 if entries remain, giving one write per cycle when ack is held high.
REQ-024 mem_wr_ack while mem_wr_req=0 SHALL be ignored.
REQ-025 Latency: a store accepted at edge N SHALL be presented no earlier than cycle N+1, and at N+1 if the buffer was empty.
REQ-026 Writes SHALL leave in acceptance order; pointers SHALL wrap modulo DEPTH with no loss or duplication.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; a push alone SHALL add 1 to count; a pop alone SHALL subtract 1.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 While reset=1 at an edge, the block SHALL set count=0, mem_wr_req=0, align_err=0 and st_ready=1 (when DEPTH>0), and SHALL zero the head/tail pointers.
REQ-030 While reset=1, mem_addr, mem_wdata and mem_byte_en SHALL read 0.
REQ-031 A reset during an unacknowledged write SHALL discard all entries; mem_wr_req SHALL be 0 from the cycle after the reset edge.
REQ-032 Stores presented during reset SHALL be ignored.

Verification
REQ-033 A word store to 0x100 with data 0xDEADBEEF and ack held 1 SHALL produce, the next cycle, mem_addr 0x100, mem_wdata 0xDEADBEEF, byte_en 1111, then count=0.
REQ-034 A byte store to 0x203 with data 0x5A SHALL produce mem_addr 0x200, byte_en 1000, mem_wdata 0x5A5A5A5A.
REQ-035 A half store to 0x302 with data 0x1234 SHALL produce byte_en 1100 and mem_wdata 0x12341234.
REQ-036 A half store to 0x301, and separately size 11, SHALL each produce an align_err pulse of one cycle and no mem_wr_req, with count unchanged.
REQ-037 With ack=0, five word stores (DEPTH=4) SHALL fill count to 4 with st_ready=0 and the 5th stalled; the outputs SHALL hold stable.
  - After ack is raised, the writes SHALL leave in order, one per cycle, and the 5th SHALL be accepted once st_ready=1.
REQ-038 Asserting reset with 3 entries pending and ack=0 SHALL give count=0 and mem_wr_req=0 the next cycle.
  - A store after release SHALL be written normally.

Source files
------------

// File: rtl/store_write_buffer.sv
// Store write buffer: formats CPU byte/half/word stores into lane-positioned
// word writes and queues them in a DEPTH-entry FIFO drained by a ready/ack memory port.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ready,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_wr_ack,
  output logic [4:0]  count,
  output logic        align_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } st_size_e;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
  } entry_t;

  entry_t           entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [4:0]       count_q, count_d;
  logic             align_err_q, align_err_d;

  entry_t entry_d;
  entry_t head_entry;
  logic   illegal;
  logic   accept;
  logic   push;
  logic   pop;

  // Store formatting and legality check.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    entry_d           = '0;
    illegal           = 1'b0;
    entry_d.word_addr = st_addr[31:2];
    case (st_size_e'(st_size))
      SIZE_BYTE: begin
        entry_d.byte_en = 4'b0001 << st_addr[1:0];
        entry_d.data    = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        entry_d.byte_en = st_addr[1] ? 4'b1100 : 4'b0011;
        entry_d.data    = {2{st_data[15:0]}};
        illegal         = st_addr[0];
      end
      SIZE_WORD: begin
        entry_d.byte_en = 4'b1111;
        entry_d.data    = st_data;
        illegal         = (st_addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign st_ready   = (count_q != 5'(DEPTH));
  assign mem_wr_req = (count_q != 5'd0);
  assign count      = count_q;
  assign align_err  = align_err_q;

  always_comb begin
    accept      = st_valid && st_ready && !reset;
    push        = accept && !illegal;
    pop         = mem_wr_req && mem_wr_ack && !reset;
    align_err_d = accept && illegal;
    head_d      = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d      = push ? tail_q + PTR_W'(1) : tail_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      align_err_q <= align_err_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q == 0 already marks it empty.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= entry_d;
    end
  end

  // Outputs are forced to zero during reset and when nothing is presented.
  always_comb begin
    head_entry = entries_q[head_q];
    if (reset || !mem_wr_req) begin
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_byte_en = '0;
    end else begin
      mem_addr    = {head_entry.word_addr, 2'b00};
      mem_wdata   = head_entry.data;
      mem_byte_en = head_entry.byte_en;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: formatted writes are queued when a
// store is accepted and compared against the head presented by the DUT.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_wr_ack;
  logic [4:0]  count;
  logic        align_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   m_count = 0;
  logic m_align = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_ready    (st_ready),
    .mem_wr_req  (mem_wr_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byte_en (mem_byte_en),
    .mem_wr_ack  (mem_wr_ack),
    .count       (count),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference formatting, built lane by lane.
  function automatic void fmt(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, output logic ok, output exp_t e);
    e.addr = {a[31:2], 2'b00};
    e.data = '0;
    e.be   = '0;
    ok     = !((sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
    for (int lane = 0; lane < 4; lane++) begin
      case (sz)
        2'd0: begin
          e.be[lane]          = (lane == int'(a[1:0]));
          e.data[8*lane +: 8] = d[7:0];
        end
        2'd1: begin
          e.be[lane]          = ((lane / 2) == int'(a[1]));
          e.data[8*lane +: 8] = (lane % 2 == 1) ? d[15:8] : d[7:0];
        end
        default: begin
          e.be[lane]          = 1'b1;
          e.data[8*lane +: 8] = d[8*lane +: 8];
        end
      endcase
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic ack, input logic rst);
    exp_t e;
    logic ok;
    logic acc;
    logic pop;
    st_valid   = v;
    st_addr    = a;
    st_data    = d;
    st_size    = sz;
    mem_wr_ack = ack;
    reset      = rst;
    #1;
    if (rst) begin
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_byte_en", 32'(mem_byte_en), 32'd0);
    end else begin
      check("st_ready", 32'(st_ready), 32'(m_count != DEPTH));
      check("mem_wr_req", 32'(mem_wr_req), 32'(m_count != 0));
      if (m_count != 0) begin
        check("head_addr", mem_addr, exp_q[0].addr);
        check("head_wdata", mem_wdata, exp_q[0].data);
        check("head_byte_en", 32'(mem_byte_en), 32'(exp_q[0].be));
      end
    end
    acc = !rst && v && (m_count != DEPTH);
    pop = !rst && ack && (m_count != 0);
    fmt(a, d, sz, ok, e);
    if (rst) begin
      exp_q.delete();
      m_align = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc && ok) exp_q.push_back(e);
      m_align = acc && !ok;
    end
    m_count = exp_q.size();
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("align_err", 32'(align_err), 32'(m_align));
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 32'd0, 32'd0, 2'd0, ack, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_count != 0; i++) idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    // Reset with a store presented; it must be ignored.
    step(1'b1, 32'h0000_0010, 32'h1111_1111, 2'd2, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0014, 32'h2222_2222, 2'd2, 1'b1, 1'b1);
    idle(1'b0);

    // Basic word, byte and half stores with ack held high.
    step(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h0000_0203, 32'h0000_005A, 2'd0, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h0000_0302, 32'h0000_1234, 2'd1, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h0000_0300, 32'hCAFE_5678, 2'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0401, 32'h0000_00A5, 2'd0, 1'b1, 1'b0);
    drain();

    // Illegal stores: misaligned half, size 11, misaligned word.
    step(1'b1, 32'h0000_0301, 32'h0000_1234, 2'd1, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h0000_0300, 32'h0000_1234, 2'd3, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h0000_0502, 32'h1234_5678, 2'd2, 1'b0, 1'b0);
    idle(1'b0);

    // Fill with ack low, hold the fifth store until it is accepted.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_1010, 32'hA000_0004, 2'd2, 1'b0, 1'b0);
    step(1'b1, 32'h0000_1010, 32'hA000_0004, 2'd2, 1'b1, 1'b0);
    step(1'b1, 32'h0000_1010, 32'hA000_0004, 2'd2, 1'b1, 1'b0);
    drain();

    // Reset while writes are pending, then a normal store afterwards.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_2000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 2'd2, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 32'h0000_2103, 32'h0000_00C3, 2'd0, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Random traffic with mixed sizes, alignments and ack patterns.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : a[1:0] & 2'b10;
      step(($urandom_range(0, 9) < 7), a, $urandom, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
